// File: rtl/elixirchip_es1_spu_op_sll.sv
// elixirchip_es1_spu_op_sll: pipelined logical shift-left with clear/valid destination register.
// Optional overflow output enabled by ELIXIRCHIP_ES1_SPU_OP_SLL_OVERFLOW_EN.
module elixirchip_es1_spu_op_sll #(
  parameter int          LATENCY         = 2,
  parameter int          DATA_BITS       = 8,
  parameter type         data_t          = logic [DATA_BITS-1:0],
  parameter int          MAX_SHIFT       = DATA_BITS,
  parameter int          SHIFT_BITS      = $clog2(MAX_SHIFT + 1),
  parameter type         shift_t         = logic [SHIFT_BITS-1:0],
  parameter data_t       CLEAR_DATA      = '1,
  parameter bit          IMMEDIATE_SHIFT = 1'b0,
  parameter bit          IMMEDIATE_DATA  = 1'b0,
  parameter              DEVICE          = "RTL",
  parameter              SIMULATION      = "false",
  parameter              DEBUG           = "false"
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cke,
  input  shift_t s_shift,
  input  data_t  s_data,
  input  logic   s_clear,
  input  logic   s_valid,
`ifdef ELIXIRCHIP_ES1_SPU_OP_SLL_OVERFLOW_EN
  output logic   m_overflow,
`endif
  output data_t  m_data
);
  typedef struct packed {
    data_t  data;
    shift_t shift;
    logic   ovr;
`ifdef ELIXIRCHIP_ES1_SPU_OP_SLL_OVERFLOW_EN
    logic   ovf;
`endif
    logic   clr;
    logic   vld;
  } tok_t;
  // Stage k applies shift bits i with i % LATENCY == k; immediate mode applies the whole shift last.
  function automatic tok_t stage_fn(input tok_t t, input int k, input shift_t ss);
    tok_t   r;
    shift_t m;
    shift_t a;
    logic   eo;
`ifdef ELIXIRCHIP_ES1_SPU_OP_SLL_OVERFLOW_EN
    logic [2*DATA_BITS-1:0] w;
`endif
    for (int i = 0; i < SHIFT_BITS; i++) m[i] = (i % LATENCY) == k;
    a  = IMMEDIATE_SHIFT ? ((k == LATENCY - 1) ? ss : '0) : (t.shift & m);
    eo = (IMMEDIATE_SHIFT ? (k == LATENCY - 1) : (k == 0))
         && (32'(IMMEDIATE_SHIFT ? ss : t.shift) >= DATA_BITS);
    r      = t;
    r.data = t.data << a;
    r.ovr  = t.ovr | eo;
`ifdef ELIXIRCHIP_ES1_SPU_OP_SLL_OVERFLOW_EN
    w      = {{DATA_BITS{1'b0}}, t.data} << a;
    r.ovf  = t.ovf | (eo ? |t.data : |w[2*DATA_BITS-1:DATA_BITS]);
`endif
    return r;
  endfunction
  tok_t src;
  tok_t last_in;
  tok_t fin;
  data_t m_data_q, m_data_d;
  always_comb begin
    src       = '0;
    src.data  = s_data;
    src.shift = IMMEDIATE_SHIFT ? '0 : s_shift;
    src.clr   = s_clear;
    src.vld   = s_valid;
  end
  if (LATENCY == 1) begin : g_direct
    assign last_in = src;
  end else begin : g_pipe
    tok_t pipe_q [LATENCY-1];
    tok_t pipe_d [LATENCY-1];
    always_comb begin
      pipe_d[0] = stage_fn(src, 0, s_shift);
      for (int k = 1; k < LATENCY - 1; k++) pipe_d[k] = stage_fn(pipe_q[k-1], k, s_shift);
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < LATENCY - 1; k++) pipe_q[k] <= '0;
      end else if (cke) begin
        pipe_q <= pipe_d;
      end
    end
    assign last_in = pipe_q[LATENCY-2];
  end
  always_comb begin
    fin      = stage_fn(last_in, LATENCY - 1, s_shift);
    m_data_d = fin.clr ? CLEAR_DATA : fin.vld ? (fin.ovr ? '0 : fin.data) : m_data_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) m_data_q <= '0;
    else if (cke) m_data_q <= m_data_d;
  end
  assign m_data = m_data_q;
`ifdef ELIXIRCHIP_ES1_SPU_OP_SLL_OVERFLOW_EN
  logic m_overflow_q, m_overflow_d;
  always_comb m_overflow_d = fin.clr ? 1'b0 : fin.vld ? fin.ovf : m_overflow_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) m_overflow_q <= 1'b0;
    else if (cke) m_overflow_q <= m_overflow_d;
  end
  assign m_overflow = m_overflow_q;
`endif
endmodule

// File: doc/elixirchip_es1_spu_op_sll.md
Name: elixirchip_es1_spu_op_sll

Overview:
- Pipelined logical shift-left operator for the ES1 SPU datapath.
- Mirror of the shift-right operator: same cke, clear and valid semantics, and the same parameter set, so the scheduler can swap the two freely.
- The barrel shift is split across LATENCY register stages; s_clear and s_valid travel alongside the data.
- Output register holds its value between valid results, so m_data acts as an SPU destination register.

Parameters:
- LATENCY, 2, number of cke-qualified register stages from input to m_data; legal range 1..4.
- DATA_BITS, 8, data width.
- data_t, logic [DATA_BITS-1:0], data type.
- MAX_SHIFT, DATA_BITS, largest shift amount the scheduler issues.
- SHIFT_BITS, $clog2(MAX_SHIFT+1), shift-amount width.
- shift_t, logic [SHIFT_BITS-1:0], shift-amount type.
- CLEAR_DATA, '1, value loaded into m_data by s_clear.
- IMMEDIATE_SHIFT, 1'b0, 1 = s_shift is constant: shift is not pipelined and the whole shift is applied in the last stage; outputs are identical either way.
- IMMEDIATE_DATA, 1'b0, 1 = s_data is constant; no functional change.
- DEVICE, "RTL", target device.
- SIMULATION, "false", simulation build.
- DEBUG, "false", debug attributes.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-low.
- cke  input  1  clock enable; all state advances only when cke=1.
- s_shift  input  SHIFT_BITS  shift amount.
- s_data  input  DATA_BITS  operand.
- s_clear  input  1  load CLEAR_DATA into m_data.
- s_valid  input  1  update m_data with the shift result.
- m_data  output  DATA_BITS  result register.

Behaviour:
- Reset (reset=0, asynchronous): m_data='0; all pipeline data/shift registers '0; all pipeline valid and clear flags 0. Release is synchronous to clk.
- Result: m_data = s_data << s_shift. If s_shift >= DATA_BITS (including values above MAX_SHIFT), the result is '0. Bits shifted out are discarded; zeros are shifted in.
- Shift staging: shift bit i is applied in stage (i mod LATENCY). Stage 0 registers the inputs with its partial shift; each later stage applies its own shift bits. The out-of-range (>= DATA_BITS) detect is computed in stage 0 and carried down the pipe.
- Latency: inputs sampled at a cke=1 edge appear on m_data after exactly LATENCY cke=1 edges. Edges with cke=0 freeze every stage, including m_data.
- Final-stage priority per token: clear=1 -> m_data=CLEAR_DATA, regardless of valid; else valid=1 -> m_data=shift result; else m_data holds.
- Back-to-back tokens on consecutive cke=1 edges are fully pipelined, one per edge; no stalls and no backpressure.
- Reset asserted mid-operation: all in-flight tokens are discarded; no result from them reaches m_data after reset is released.

Optional Feature:
- Macro: ELIXIRCHIP_ES1_SPU_OP_SLL_OVERFLOW_EN.
- With the macro defined:
  - Adds output port m_overflow, 1 bit, reset 0.
  - m_overflow=1 when any 1 bit of s_data was shifted out, or when the shift is >= DATA_BITS with s_data != 0.
  - It travels and updates with the same priority as m_data: clear -> 0; valid -> computed value; otherwise hold.
- Without the macro: the port is absent and there is no overflow logic.

Test Plan (DATA_BITS=8, LATENCY=2 unless noted):
- Reset: hold reset=0, then release; drive s_valid=0 -> m_data stays 8'h00.
- Basic shift: s_data=8'hA5, s_shift=3, s_valid=1, cke=1 constant -> m_data=8'h28 exactly 2 edges later; with the macro, m_overflow=1.
- Out-of-range and clear priority: s_shift=8, s_data=8'hFF, valid=1 -> 8'h00. Next token s_clear=1, s_valid=1 -> 8'hFF (CLEAR_DATA). Next token valid=0 -> 8'hFF held.
- cke stall: issue s_data=8'h01, s_shift=7, then cke=0 for 3 edges -> m_data unchanged during the stall; 8'h80 appears on the second cke=1 edge after issue.
- Mid-operation reset: issue two valid tokens, assert reset on the next edge, then release -> m_data=8'h00 and neither token appears.
- Random sweep: LATENCY 1..4, IMMEDIATE_SHIFT 0/1, random cke (~90% high), random flags -> m_data matches a scoreboard model delayed by LATENCY cke edges.
